// File: rtl/riscv_pkg.sv
// Shared RISC-V constants used by the front-end blocks.
package riscv_pkg;

    // Canonical NOP: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR    = 32'h00000013;
    localparam int          XLEN_DEFAULT = 32;

endpackage : riscv_pkg

// File: rtl/fq_storage.sv
// Entry storage for the fetch queue: DEPTH words of {pc, instr}.
// One synchronous write port and one asynchronous read port. The contents
// are not reset, because occupancy is tracked entirely by the pointers
// and the count in the parent.
module fq_storage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int ADDRW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [ADDRW-1:0]  wrAddr,
    input  logic [2*XLEN-1:0] wrData,
    input  logic [ADDRW-1:0]  rdAddr,
    output logic [2*XLEN-1:0] rdData
);

    logic [2*XLEN-1:0] mem [DEPTH];

    // Write the entry selected by the write pointer
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Asynchronous read of the entry selected by the read pointer
    always_comb begin
        rdData = mem[rdAddr];
    end

endmodule : fq_storage

// File: rtl/fetch_queue.sv
// Fetch queue between instruction fetch and decode.
//
// Handshake: both sides use valid/ready. A transfer happens on a rising
// edge only when valid and ready are both high and flush is low. Once
// valid is raised the producer holds its payload until it is accepted.
// push_ready depends only on the stored count, so it never reflects
// pop_ready in the same cycle; pop outputs come from stored entries only,
// giving one cycle of latency from push to pop.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int DEPTH    = 4,
    parameter int NOP_FILL = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [XLEN-1:0]          push_instr,
    input  logic [XLEN-1:0]          push_pc,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [XLEN-1:0]          pop_instr,
    output logic [XLEN-1:0]          pop_pc,
    output logic [XLEN-1:0]          pop_pcplus4,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    // DEPTH must be a power of two so the pointers wrap for free
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gBadDepth
            $error("fetch_queue: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    logic [PTRW-1:0]   rdPtr;
    logic [PTRW-1:0]   wrPtr;
    logic [CNTW-1:0]   occupancy;
    logic              pushFire;
    logic              popFire;
    logic              isEmpty;
    logic [2*XLEN-1:0] headData;
    logic [XLEN-1:0]   headInstr;
    logic [XLEN-1:0]   headPc;

    // Handshake status derived from stored occupancy only
    always_comb begin
        isEmpty    = (occupancy == '0);
        push_ready = (occupancy < CNTW'(DEPTH));
        pop_valid  = !isEmpty;
        pushFire   = push_valid && push_ready && !flush;
        popFire    = pop_valid && pop_ready && !flush;
    end

    // Pointer and occupancy tracking; flush wins over any push or pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            occupancy <= '0;
        end else if (flush) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            occupancy <= '0;
        end else begin
            if (pushFire) begin
                wrPtr <= wrPtr + PTRW'(1);
            end
            if (popFire) begin
                rdPtr <= rdPtr + PTRW'(1);
            end
            if (pushFire && !popFire) begin
                occupancy <= occupancy + CNTW'(1);
            end else if (popFire && !pushFire) begin
                occupancy <= occupancy - CNTW'(1);
            end
        end
    end

    fq_storage #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .ADDRW (PTRW)
    ) uStorage (
        .clk    (clk),
        .wrEn   (pushFire),
        .wrAddr (wrPtr),
        .wrData ({push_pc, push_instr}),
        .rdAddr (rdPtr),
        .rdData (headData)
    );

    // Head presentation; an empty queue shows a NOP at PC 0 when enabled
    always_comb begin
        headInstr = headData[XLEN-1:0];
        headPc    = headData[2*XLEN-1:XLEN];
        if (isEmpty && (NOP_FILL != 0)) begin
            pop_instr = XLEN'(NOP_INSTR);
            pop_pc    = '0;
        end else begin
            pop_instr = headInstr;
            pop_pc    = headPc;
        end
        pop_pcplus4 = pop_pc + XLEN'(4);
        count       = occupancy;
    end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (XLEN=32, DEPTH=4, NOP_FILL=1).
module tb_fetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNTW  = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h00000013;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            push_valid = 1'b0;
    logic            push_ready;
    logic [XLEN-1:0] push_instr = '0;
    logic [XLEN-1:0] push_pc = '0;
    logic            pop_valid;
    logic            pop_ready = 1'b0;
    logic [XLEN-1:0] pop_instr;
    logic [XLEN-1:0] pop_pc;
    logic [XLEN-1:0] pop_pcplus4;
    logic [CNTW-1:0] count;

    logic [XLEN-1:0] exp_q[$];
    int              checkCount = 0;
    int              passCount  = 0;

    fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .NOP_FILL (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .push_instr  (push_instr),
        .push_pc     (push_pc),
        .pop_valid   (pop_valid),
        .pop_ready   (pop_ready),
        .pop_instr   (pop_instr),
        .pop_pc      (pop_pc),
        .pop_pcplus4 (pop_pcplus4),
        .count       (count)
    );

    // clock / reset block: 10 ns period, reset driven from the main sequence
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [XLEN-1:0] instrFor(input logic [XLEN-1:0] pc);
        return pc ^ 32'hA5A5_0003;
    endfunction

    // advance one edge and settle 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
    endtask

    // push one entry with decode stalled
    task automatic pushOne(input logic [XLEN-1:0] pc);
        push_valid = 1'b1;
        push_pc    = pc;
        push_instr = instrFor(pc);
        pop_ready  = 1'b0;
        if (push_ready) exp_q.push_back(pc);
        tick();
        idle();
    endtask

    // pop one entry, checking the head against the scoreboard first
    task automatic popCheck(input string tag);
        logic [XLEN-1:0] exp_pc;
        exp_pc = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
        check({tag, "_valid"}, 64'(pop_valid), 64'd1);
        check({tag, "_pc"}, 64'(pop_pc), 64'(exp_pc));
        check({tag, "_instr"}, 64'(pop_instr), 64'(instrFor(exp_pc)));
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        tick();
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        idle();
    endtask

    initial begin
        // ---- reset state ----
        #1 reset = 1'b0;
        #1;
        check("rst_pop_valid", 64'(pop_valid), 64'd0);
        check("rst_push_ready", 64'(push_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_pop_instr", 64'(pop_instr), 64'(NOP));
        check("rst_pop_pc", 64'(pop_pc), 64'd0);
        check("rst_pcplus4", 64'(pop_pcplus4), 64'd4);
        #10 reset = 1'b1;
        tick();

        // ---- fill to full ----
        pushOne(32'h0);
        check("fill_latency_valid", 64'(pop_valid), 64'd1);
        check("fill_latency_pc", 64'(pop_pc), 64'h0);
        pushOne(32'h4);
        pushOne(32'h8);
        pushOne(32'hC);
        check("full_count", 64'(count), 64'd4);
        check("full_push_ready", 64'(push_ready), 64'd0);
        // fifth attempt must be refused
        push_valid = 1'b1;
        push_pc    = 32'h10;
        push_instr = instrFor(32'h10);
        tick();
        idle();
        check("overflow_count", 64'(count), 64'd4);
        check("overflow_head", 64'(pop_pc), 64'h0);

        // ---- drain ----
        for (int i = 0; i < 4; i++) begin
            check("drain_pcplus4", 64'(pop_pcplus4), 64'(exp_q[0] + 32'd4));
            popCheck("drain");
        end
        check("drain_empty_valid", 64'(pop_valid), 64'd0);
        check("drain_empty_instr", 64'(pop_instr), 64'(NOP));
        check("drain_empty_pc", 64'(pop_pc), 64'd0);
        check("drain_empty_count", 64'(count), 64'd0);
        check("drain_empty_qsize", 64'(exp_q.size()), 64'd0);

        // ---- streaming at count 2 ----
        pushOne(32'h100);
        pushOne(32'h104);
        for (int i = 0; i < 20; i++) begin
            logic [XLEN-1:0] pc;
            pc = 32'h108 + 32'(i * 4);
            check("stream_head", 64'(pop_pc), 64'(exp_q[0]));
            push_valid = 1'b1;
            push_pc    = pc;
            push_instr = instrFor(pc);
            pop_ready  = 1'b1;
            tick();
            exp_q.push_back(pc);
            void'(exp_q.pop_front());
            check("stream_count", 64'(count), 64'd2);
        end
        idle();
        popCheck("stream_tail0");
        popCheck("stream_tail1");
        check("stream_done_count", 64'(count), 64'd0);

        // ---- flush with push and pop ----
        pushOne(32'h200);
        pushOne(32'h204);
        pushOne(32'h208);
        check("preflush_count", 64'(count), 64'd3);
        flush      = 1'b1;
        push_valid = 1'b1;
        push_pc    = 32'h40;
        push_instr = instrFor(32'h40);
        pop_ready  = 1'b1;
        tick();
        idle();
        exp_q.delete();
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(pop_valid), 64'd0);
        pushOne(32'h300);
        check("postflush_count", 64'(count), 64'd1);
        popCheck("postflush");

        // ---- PC+4 wrap ----
        pushOne(32'hFFFF_FFFC);
        check("wrap_pcplus4", 64'(pop_pcplus4), 64'h0);
        popCheck("wrap");

        // ---- asynchronous reset mid-operation ----
        pushOne(32'h500);
        pushOne(32'h504);
        check("prereset_count", 64'(count), 64'd2);
        #3 reset = 1'b0;
        #1;
        check("areset_valid", 64'(pop_valid), 64'd0);
        check("areset_count", 64'(count), 64'd0);
        check("areset_push_ready", 64'(push_ready), 64'd1);
        exp_q.delete();
        #7 reset = 1'b1;
        tick();
        pushOne(32'h600);
        popCheck("postreset");
        check("final_count", 64'(count), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_fetch_queue
